// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between four bus masters and the arbiter.
// Requests and grants are active low; mSel carries the owner index to the master mux.
interface bus_arbiter_if;
  logic       m0Req_;
  logic       m1Req_;
  logic       m2Req_;
  logic       m3Req_;
  logic       m0Grnt_;
  logic       m1Grnt_;
  logic       m2Grnt_;
  logic       m3Grnt_;
  logic [1:0] mSel;

  modport master (
    output m0Req_, m1Req_, m2Req_, m3Req_,
    input  m0Grnt_, m1Grnt_, m2Grnt_, m3Grnt_, mSel
  );

  modport slave (
    input  m0Req_, m1Req_, m2Req_, m3Req_,
    output m0Grnt_, m1Grnt_, m2Grnt_, m3Grnt_, mSel
  );
endinterface

// File: rtl/bus_arbiter.sv
// Four-master round-robin bus arbiter with bus parking and an optional hold limit.
// Grant follows the request edge by one cycle; exactly one grant is low at all times.
module bus_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic         clk,
  input  logic         reset,
  bus_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

  logic [1:0]       owner_q, owner_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [3:0]       req;
  logic             own_req;
  logic             others_req;
  logic             keep;
  logic             found;
  logic [1:0]       cand;

  always_comb begin
    req = ~{bus.m3Req_, bus.m2Req_, bus.m1Req_, bus.m0Req_};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q    <= 2'd0;
      hold_cnt_q <= '0;
    end else begin
      owner_q    <= owner_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  always_comb begin
    own_req    = req[owner_q];
    others_req = |(req & ~(4'b0001 << owner_q));
    keep       = own_req && ((MAX_HOLD == 0) || (hold_cnt_q < HOLD_LIM) || !others_req);
    owner_d    = owner_q;
    hold_cnt_d = '0;
    found      = 1'b0;
    cand       = 2'd0;
    if (keep) begin
      // With MAX_HOLD==0 the counter simply sits at zero.
      hold_cnt_d = (hold_cnt_q >= HOLD_LIM) ? HOLD_LIM : hold_cnt_q + 1'b1;
    end else begin
      for (int i = 1; i < 4; i++) begin
        cand = owner_q + 2'(i);
        if (!found && req[cand]) begin
          owner_d = cand;
          found   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.m0Grnt_ = (owner_q != 2'd0);
    bus.m1Grnt_ = (owner_q != 2'd1);
    bus.m2Grnt_ = (owner_q != 2'd2);
    bus.m3Grnt_ = (owner_q != 2'd3);
    bus.mSel    = owner_q;
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench: arbiter with hold limit 4 (dut_a) and with unlimited hold (dut_b).
module tb_bus_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  bus_arbiter_if a_if ();
  bus_arbiter_if b_if ();

  bus_arbiter #(.MAX_HOLD(4), .CNT_W(3)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (a_if.slave)
  );

  bus_arbiter #(.MAX_HOLD(0), .CNT_W(5)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] grnt_of(input logic [1:0] o);
    logic [3:0] g;
    g = 4'b1111;
    g[o] = 1'b0;
    return g;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic [1:0] o);
    check({tag, "_grnt"}, {4'b0, a_if.m3Grnt_, a_if.m2Grnt_, a_if.m1Grnt_, a_if.m0Grnt_},
          {4'b0, grnt_of(o)});
    check({tag, "_sel"}, {6'b0, a_if.mSel}, {6'b0, o});
  endtask

  task automatic check_b(input string tag, input logic [1:0] o);
    check({tag, "_grnt"}, {4'b0, b_if.m3Grnt_, b_if.m2Grnt_, b_if.m1Grnt_, b_if.m0Grnt_},
          {4'b0, grnt_of(o)});
    check({tag, "_sel"}, {6'b0, b_if.mSel}, {6'b0, o});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic [3:0] req_n);
    {a_if.m3Req_, a_if.m2Req_, a_if.m1Req_, a_if.m0Req_} = req_n;
  endtask

  task automatic set_b(input logic [3:0] req_n);
    {b_if.m3Req_, b_if.m2Req_, b_if.m1Req_, b_if.m0Req_} = req_n;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    set_a(4'b1111);
    set_b(4'b1111);

    // 1. reset held two cycles, then five idle cycles parked on master 0
    step();
    check_a("rst_c0", 2'd0);
    step();
    check_a("rst_c1", 2'd0);
    check("rst_hold", {5'b0, dut_a.hold_cnt_q}, 8'd0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_a("idle", 2'd0);
      check_b("idle_b", 2'd0);
    end

    // 2. lone request from master 2, then release -> parked on 2
    set_a(4'b1011);
    step();
    check_a("m2_grant", 2'd2);
    for (int i = 0; i < 3; i++) begin
      step();
      check_a("m2_hold", 2'd2);
    end
    set_a(4'b1111);
    step();
    check_a("m2_park", 2'd2);
    check("m2_park_cnt", {5'b0, dut_a.hold_cnt_q}, 8'd0);

    // 3. owner 1 releases with 0 and 3 waiting -> 3 first, then 0
    set_a(4'b1101);
    step();
    check_a("m1_grant", 2'd1);
    set_a(4'b0110);
    step();
    check_a("rr_1_to_3", 2'd3);
    set_a(4'b1110);
    step();
    check_a("rr_3_to_0", 2'd0);
    set_a(4'b1111);
    step();
    check_a("park_0", 2'd0);

    // 4. masters 0 and 1 both requesting: blocks of five cycles each
    set_a(4'b1100);
    for (int k = 1; k <= 20; k++) begin
      step();
      check_a("hold_alt", ((k / 5) % 2 == 0) ? 2'd0 : 2'd1);
    end
    set_a(4'b1111);
    step();
    check_a("alt_park", 2'd0);

    // 5. unlimited hold: master 0 keeps the bus while master 1 waits
    set_b(4'b1100);
    for (int k = 0; k < 100; k++) begin
      step();
      check_b("nolimit", 2'd0);
    end
    set_b(4'b1101);
    step();
    check_b("nolimit_rel", 2'd1);
    set_b(4'b1111);
    step();
    check_b("nolimit_park", 2'd1);

    // 6. reset while master 3 owns and requests
    set_a(4'b0111);
    step();
    check_a("m3_grant", 2'd3);
    step();
    check_a("m3_hold", 2'd3);
    reset = 1'b1;
    step();
    check_a("rst_mid", 2'd0);
    check("rst_mid_cnt", {5'b0, dut_a.hold_cnt_q}, 8'd0);
    reset = 1'b0;
    step();
    check_a("m3_regain", 2'd3);
    set_a(4'b1111);
    step();
    check_a("m3_park", 2'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
